// File: rtl/reverb_dram_pkg.sv
// Shared constants, types and helpers for the reverb DRAM write path.
package reverb_dram_pkg;

  localparam int PIX_W               = 16;
  localparam int WORD_W              = 128;
  localparam int BEATS_PER_WORD      = 8;
  localparam int IDX_W               = $clog2(BEATS_PER_WORD);
  localparam int DEFAULT_FRAME_WORDS = 115200;

  // SYNC waits for the first end-of-frame; RUN packs and addresses words.
  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } wr_state_t;

  // Returns word with lane idx replaced by pix; lane 0 sits at bits [15:0].
  function automatic logic [WORD_W-1:0] insert_lane(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  idx,
    input logic [PIX_W-1:0]  pix
  );
    logic [WORD_W-1:0] r;
    r = word;
    r[idx*PIX_W +: PIX_W] = pix;
    return r;
  endfunction

endpackage

// File: rtl/reverb_dram_writer_if.sv
// Addressed 128-bit write request channel towards the memory arbiter.
interface reverb_dram_writer_if
  import reverb_dram_pkg::*;
#(
  parameter int ADDR_W = 27
);

  logic [WORD_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              valid;
  logic              ready;

  modport master (output data, output addr, output valid, input ready);
  modport slave  (input data, input addr, input valid, output ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered output stage. The output register counts
// towards DEPTH, so the FIFO holds exactly DEPTH entries in total. A pop in the
// same cycle as a push to a full FIFO frees the slot the push needs.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16   // power of two, at least 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] mem_cnt;
  logic             out_valid;
  logic             do_pop;
  logic             do_push;
  logic             do_load;

  assign empty   = !out_valid;
  assign full    = (mem_cnt + CNT_W'(out_valid)) == CNT_W'(DEPTH);
  assign do_pop  = pop && out_valid;
  assign do_push = push && (!full || do_pop);
  assign do_load = (mem_cnt != '0) && (!out_valid || do_pop);

  // Storage array write port.
  // NOTE: the storage array has no reset; occupancy is tracked by mem_cnt and
  // out_valid, so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered output stage.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_load) rd_ptr <= rd_ptr + PTR_W'(1);
      mem_cnt <= mem_cnt + CNT_W'(do_push) - CNT_W'(do_load);
      if (do_load) begin
        dout      <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else if (do_pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reverb_dram_writer.sv
// Packs the 16-bit reverb feedback stream into 128-bit, frame-addressed DRAM
// write requests. The source cannot stall, so a FIFO absorbs arbiter
// backpressure and words that find it full are dropped (flagged by overflow).
module reverb_dram_writer
  import reverb_dram_pkg::*;
#(
  parameter int                FIFO_DEPTH  = 16,
  parameter int                ADDR_W      = 27,
  parameter logic [ADDR_W-1:0] FRAME_BASE  = '0,
  parameter int                FRAME_WORDS = DEFAULT_FRAME_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     s_data,
  input  logic                 s_valid,
  input  logic                 s_tlast,
  reverb_dram_writer_if.master m,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 frame_error
);

  localparam int CNT_W  = $clog2(FRAME_WORDS + 1);
  localparam int FILL_W = IDX_W + 1;
  localparam int ENTRY_W = WORD_W + ADDR_W;

  wr_state_t         state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [WORD_W-1:0] pack, pack_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              push_pend, push_pend_n;
  logic [WORD_W-1:0] push_word, push_word_n;
  logic [ADDR_W-1:0] push_addr, push_addr_n;
  logic              done_n;
  logic              err_n;

  logic [WORD_W-1:0] beat_word;
  logic [FILL_W-1:0] fill;
  logic [CNT_W-1:0]  word_idx;
  logic              emit;

  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               drop;

  // Next-state, packer, word counter and push request.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    pack_n      = pack;
    count_n     = count;
    push_pend_n = 1'b0;
    push_word_n = push_word;
    push_addr_n = push_addr;
    done_n      = 1'b0;
    err_n       = frame_error;
    beat_word   = pack;
    fill        = '0;
    word_idx    = '0;
    emit        = 1'b0;

    unique case (state)
      SYNC: begin
        if (s_tlast) begin
          state_n = RUN;
          idx_n   = '0;
          pack_n  = '0;
          count_n = '0;
        end
      end
      RUN: begin
        beat_word = s_valid ? insert_lane(pack, idx, s_data) : pack;
        fill      = {1'b0, idx} + FILL_W'(s_valid);
        emit      = (fill == FILL_W'(BEATS_PER_WORD)) || (s_tlast && (fill != '0));
        // A word beyond the frame length wraps to slot 0 so the address
        // never leaves the frame region.
        word_idx  = (count == CNT_W'(FRAME_WORDS)) ? '0 : count;

        if (emit) begin
          push_pend_n = 1'b1;
          push_word_n = beat_word;
          push_addr_n = FRAME_BASE + (ADDR_W'(word_idx) << 3);
          count_n     = word_idx + CNT_W'(1);
          pack_n      = '0;
          idx_n       = '0;
          if (count == CNT_W'(FRAME_WORDS)) err_n = 1'b1;
        end else begin
          pack_n = beat_word;
          idx_n  = fill[IDX_W-1:0];
        end

        if (s_tlast) begin
          if (count_n != CNT_W'(FRAME_WORDS)) err_n = 1'b1;
          count_n = '0;
          idx_n   = '0;
          pack_n  = '0;
          done_n  = 1'b1;
        end
      end
      default: state_n = SYNC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= SYNC;
    else     state <= state_n;
  end

  // Packer, counter, push stage and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      pack        <= '0;
      count       <= '0;
      push_pend   <= 1'b0;
      push_word   <= '0;
      push_addr   <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      idx         <= idx_n;
      pack        <= pack_n;
      count       <= count_n;
      push_pend   <= push_pend_n;
      push_word   <= push_word_n;
      push_addr   <= push_addr_n;
      frame_done  <= done_n;
      frame_error <= err_n;
      if (drop) overflow <= 1'b1;
    end
  end

  // A pending push is lost only when the FIFO is full and nothing leaves it
  // in the same cycle.
  assign drop = push_pend && fifo_full && !(m.valid && m.ready);

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_pend),
    .din   ({push_word, push_addr}),
    .pop   (m.ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m.data  = fifo_dout[ADDR_W +: WORD_W];
  assign m.addr  = fifo_dout[ADDR_W-1:0];
  assign m.valid = !fifo_empty;

endmodule

// File: tb/tb_reverb_dram_writer.sv
// Randomised scoreboard bench for reverb_dram_writer. A frame-level model turns
// each stimulus cycle into expected write requests; an independent monitor pops
// and compares whenever the DUT hands a request to the arbiter.
module tb_reverb_dram_writer;
  import reverb_dram_pkg::*;

  localparam int FIFO_DEPTH = 16;
  localparam int ADDR_W     = 27;
  localparam int FW         = 24;

  typedef struct {
    logic [127:0]      data;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_tlast;
  logic        frame_done;
  logic        overflow;
  logic        frame_error;

  reverb_dram_writer_if #(.ADDR_W(ADDR_W)) m_if ();

  reverb_dram_writer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .ADDR_W      (ADDR_W),
    .FRAME_BASE  ('0),
    .FRAME_WORDS (FW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_tlast     (s_tlast),
    .m           (m_if),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  exp_t        exp_q[$];
  logic [15:0] cur[$];
  bit          synced;
  int          n_words;
  bit          stalled;
  bit          rand_ready;
  int          exp_done;
  bit          exp_err;
  bit          exp_ovf;

  // Monitor state.
  int                seen_done = 0;
  int                done_base = 0;
  bit                hold_chk  = 1'b0;
  logic [127:0]      hold_data;
  logic [ADDR_W-1:0] hold_addr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    cur.delete();
    synced   = 1'b0;
    n_words  = 0;
    exp_done = 0;
    exp_err  = 1'b0;
    exp_ovf  = 1'b0;
  endfunction

  function automatic void model_emit();
    exp_t e;
    e.data = '0;
    foreach (cur[i]) e.data = e.data | (128'(cur[i]) << (16 * i));
    if (n_words >= FW) exp_err = 1'b1;
    e.addr = ADDR_W'(8 * (n_words % FW));
    n_words++;
    cur.delete();
    if (stalled && exp_q.size() >= FIFO_DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(e);
  endfunction

  function automatic void model_step(input bit v, input logic [15:0] d, input bit t);
    if (!synced) begin
      if (t) begin
        synced  = 1'b1;
        n_words = 0;
        cur.delete();
      end
      return;
    end
    if (v) cur.push_back(d);
    if (cur.size() == 8 || (t && cur.size() > 0)) model_emit();
    if (t) begin
      if (n_words != FW) exp_err = 1'b1;
      n_words = 0;
      exp_done++;
    end
  endfunction

  // One stimulus cycle: drive just after the edge and tell the model.
  task automatic step(input bit v, input logic [15:0] d, input bit t);
    @(posedge clk);
    #1;
    s_valid = v;
    s_data  = d;
    s_tlast = t;
    if (rand_ready) m_if.ready = ($urandom_range(0, 3) != 0);
    model_step(v, d, t);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 1'b0);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 16'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_tlast = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    done_base = seen_done;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_m_valid"},     m_if.valid,  0);
    check({tag, "_m_data"},      m_if.data,   0);
    check({tag, "_m_addr"},      m_if.addr,   0);
    check({tag, "_frame_done"},  frame_done,  0);
    check({tag, "_overflow"},    overflow,    0);
    check({tag, "_frame_error"}, frame_error, 0);
  endtask

  // Release backpressure and wait (bounded) for every expected word.
  task automatic drain(input string tag);
    int n = 0;
    rand_ready = 1'b0;
    stalled    = 1'b0;
    m_if.ready = 1'b1;
    while (exp_q.size() != 0 && n < 600) begin
      idle(1);
      n++;
    end
    check({tag, "_drain_left"}, exp_q.size(), 0);
    idle(4);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_done_count"}, seen_done - done_base, exp_done);
    check({tag, "_frame_error"},      frame_error,           exp_err);
    check({tag, "_overflow"},         overflow,              exp_ovf);
  endtask

  // Scoreboard monitor: compares on accepted requests, checks hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      exp_t e;
      if (frame_done) seen_done++;
      if (hold_chk) begin
        check("stall_hold_valid", m_if.valid, 1);
        check("stall_hold_data",  m_if.data,  hold_data);
        check("stall_hold_addr",  m_if.addr,  hold_addr);
      end
      hold_chk  = m_if.valid && !m_if.ready;
      hold_data = m_if.data;
      hold_addr = m_if.addr;
      if (m_if.valid && m_if.ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got addr %0h data %0h expected no request",
                   m_if.addr, m_if.data);
        end else begin
          checks--;
          e = exp_q.pop_front();
          check("word_data", m_if.data, e.data);
          check("word_addr", m_if.addr, e.addr);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = '0;
    s_tlast    = 1'b0;
    m_if.ready = 1'b1;
    stalled    = 1'b0;
    rand_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    do_reset();
    check_outputs_zero("reset");

    // Sync: beats before the first tlast are ignored.
    for (int i = 0; i < 20; i++) step(1'b1, 16'($urandom), 1'b0);
    idle(3);
    check("presync_m_valid", m_if.valid, 0);
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 16'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    check("latency_e1_valid", m_if.valid, 0);
    @(negedge clk);
    check("latency_e2_valid", m_if.valid, 0);
    @(negedge clk);
    check("latency_e3_valid", m_if.valid, 1);
    check("first_word_data",  m_if.data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    check("first_word_addr",  m_if.addr, 0);
    drain("sync");
    check("sync_frame_done_count", seen_done - done_base, 0);

    // Full frame with random gaps and random arbiter readiness, then a new frame.
    do_reset();
    step(1'b0, '0, 1'b1);
    rand_ready = 1'b1;
    begin
      int sent = 0;
      while (sent < FW * 8) begin
        bit v = ($urandom_range(0, 3) != 0);
        step(v, 16'($urandom), 1'b0);
        if (v) sent++;
      end
    end
    step(1'b0, '0, 1'b1);
    idle(2);
    check("full_frame_error", frame_error, 0);
    rand_ready = 1'b1;
    beats(16);
    drain("full");
    check_flags("full");

    // Partial flush: 3 beats then tlast.
    do_reset();
    step(1'b0, '0, 1'b1);
    beats(3);
    step(1'b0, '0, 1'b1);
    drain("partial");
    check_flags("partial");

    // Backpressure: 20 words into a 16-deep FIFO while stalled.
    do_reset();
    step(1'b0, '0, 1'b1);
    m_if.ready = 1'b0;
    stalled    = 1'b1;
    beats(160);
    idle(10);
    check("bp_overflow", overflow, exp_ovf);
    check("bp_m_valid",  m_if.valid, 1);
    @(posedge clk);
    #1;
    m_if.ready = 1'b1;
    stalled    = 1'b0;
    beats(32);
    drain("bp");
    check_flags("bp");

    // Reset mid-frame with a stalled word on the output.
    do_reset();
    step(1'b0, '0, 1'b1);
    m_if.ready = 1'b0;
    stalled    = 1'b1;
    beats(13);
    idle(3);
    check("premid_m_valid", m_if.valid, 1);
    do_reset();
    stalled    = 1'b0;
    m_if.ready = 1'b1;
    check_outputs_zero("midreset");
    beats(24);
    idle(4);
    check("midreset_unsynced_valid", m_if.valid, 0);
    step(1'b0, '0, 1'b1);
    beats(8);
    drain("midreset");
    check_flags("midreset");

    // tlast coincident with the 8th beat: one word, one frame_done.
    do_reset();
    step(1'b0, '0, 1'b1);
    beats(7);
    step(1'b1, 16'($urandom), 1'b1);
    drain("coincident");
    check_flags("coincident");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
